// File: rtl/cbfp0_grp_sched.sv
`timescale 1ns/1ps
// cbfp0_grp_sched
// Sequencing controller for the CBFP stage-0 datapath. Input beats are
// grouped into GROUP_LEN-beat groups and written alternately into a two-bank
// ping-pong buffer. The running-min accumulator is cleared on the first beat
// of each group. min_fin_en fires LAT_MIN cycles after the group's last beat.
// Banks are drained in write order under scale_ready backpressure.
//
// Ports:
//   clk, rstn        clock, synchronous active-low reset
//   din_valid/ready  input beat handshake
//   scale_ready      downstream can take a read beat
//   min_clr          restart running min (first accepted beat of a group)
//   min_acc_en       accumulate accepted beat into the min
//   wr_en/bank/addr  buffer write port
//   min_fin_en       one-cycle pulse: min of bank fin_bank is valid
//   fin_bank         bank whose min just finished
//   rd_en/bank/addr  buffer read / scale strobe
//   rd_group         index of the group being drained
//   frame_done       pulse with the last read of group NUM_GROUPS-1
module cbfp0_grp_sched #(
  parameter int GROUP_LEN  = 16,
  parameter int NUM_GROUPS = 32,
  parameter int LAT_MIN    = 4
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          din_valid,
  output logic                          din_ready,
  input  logic                          scale_ready,
  output logic                          min_clr,
  output logic                          min_acc_en,
  output logic                          wr_en,
  output logic                          wr_bank,
  output logic [$clog2(GROUP_LEN)-1:0]  wr_addr,
  output logic                          min_fin_en,
  output logic                          fin_bank,
  output logic                          rd_en,
  output logic                          rd_bank,
  output logic [$clog2(GROUP_LEN)-1:0]  rd_addr,
  output logic [$clog2(NUM_GROUPS)-1:0] rd_group,
  output logic                          frame_done
);

  localparam int AW = $clog2(GROUP_LEN);
  localparam int GW = $clog2(NUM_GROUPS);
  localparam int CW = $clog2(LAT_MIN + 1);

  typedef enum logic [2:0] {
    ST_EMPTY,
    ST_FILL,
    ST_WAIT_MIN,
    ST_READY,
    ST_DRAIN
  } bank_state_t;

  logic          wr_bank_reg, wr_bank_next;
  logic [AW-1:0] wr_addr_reg, wr_addr_next;
  logic          rd_bank_reg, rd_bank_next;
  logic [AW-1:0] rd_addr_reg, rd_addr_next;
  logic [GW-1:0] rd_group_reg, rd_group_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          fin_bank_reg, fin_bank_next;

  bank_state_t   bank_st [2];
  bank_state_t   wr_state, rd_state;
  logic          accept, wr_last, rd_last, rd_fire, fin_pulse;

  assign wr_state = bank_st[wr_bank_reg];
  assign rd_state = bank_st[rd_bank_reg];
  assign wr_last  = (wr_addr_reg == AW'(GROUP_LEN - 1));
  assign rd_last  = (rd_addr_reg == AW'(GROUP_LEN - 1));

  // Strobes are held low while reset is asserted so nothing leaks out of a
  // state that is about to be discarded.
  assign din_ready = rstn && (wr_state == ST_EMPTY || wr_state == ST_FILL);
  assign accept    = din_valid && din_ready;
  assign rd_fire   = rstn && scale_ready &&
                     (rd_state == ST_READY || rd_state == ST_DRAIN);
  // One countdown is enough: the next group needs GROUP_LEN > LAT_MIN beats
  // before it can reload it.
  assign fin_pulse = rstn && (cnt_reg == CW'(1));

  assign min_clr    = accept && (wr_state == ST_EMPTY);
  assign min_acc_en = accept;
  assign wr_en      = accept;
  assign wr_bank    = wr_bank_reg;
  assign wr_addr    = wr_addr_reg;
  assign min_fin_en = fin_pulse;
  assign fin_bank   = fin_bank_reg;
  assign rd_en      = rd_fire;
  assign rd_bank    = rd_bank_reg;
  assign rd_addr    = rd_addr_reg;
  assign rd_group   = rd_group_reg;
  assign frame_done = rd_fire && rd_last && (rd_group_reg == GW'(NUM_GROUPS - 1));

  // Per-bank lifecycle. A bank only reacts to the side currently pointing at
  // it, so write-side and read-side transitions on different banks coexist.
  for (genvar gi = 0; gi < 2; gi++) begin : g_bank
    localparam logic BANK_ID = (gi != 0);
    bank_state_t state_reg, state_next;
    logic wr_hit, rd_hit, fin_hit;

    assign wr_hit  = accept && (wr_bank_reg == BANK_ID);
    assign rd_hit  = rd_fire && (rd_bank_reg == BANK_ID);
    assign fin_hit = fin_pulse && (fin_bank_reg == BANK_ID);

    always_comb begin
      state_next = state_reg;
      case (state_reg)
        ST_EMPTY:    if (wr_hit) state_next = ST_FILL;
        ST_FILL:     if (wr_hit && wr_last) state_next = ST_WAIT_MIN;
        ST_WAIT_MIN: if (fin_hit) state_next = ST_READY;
        ST_READY:    if (rd_hit) state_next = ST_DRAIN;
        ST_DRAIN:    if (rd_hit && rd_last) state_next = ST_EMPTY;
        default:     state_next = ST_EMPTY;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!rstn) state_reg <= ST_EMPTY;
      else       state_reg <= state_next;
    end

    assign bank_st[gi] = state_reg;
  end

  always_comb begin
    wr_bank_next  = wr_bank_reg;
    wr_addr_next  = wr_addr_reg;
    rd_bank_next  = rd_bank_reg;
    rd_addr_next  = rd_addr_reg;
    rd_group_next = rd_group_reg;
    cnt_next      = cnt_reg;
    fin_bank_next = fin_bank_reg;

    // Addresses wrap naturally because GROUP_LEN is a power of two.
    if (accept) begin
      wr_addr_next = wr_addr_reg + 1'b1;
      if (wr_last) wr_bank_next = ~wr_bank_reg;
    end

    if (rd_fire) begin
      rd_addr_next = rd_addr_reg + 1'b1;
      if (rd_last) begin
        rd_bank_next  = ~rd_bank_reg;
        rd_group_next = (rd_group_reg == GW'(NUM_GROUPS - 1)) ? '0 : rd_group_reg + 1'b1;
      end
    end

    if (accept && wr_last) begin
      cnt_next      = CW'(LAT_MIN);
      fin_bank_next = wr_bank_reg;
    end else if (cnt_reg != '0) begin
      cnt_next = cnt_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_bank_reg  <= 1'b0;
      wr_addr_reg  <= '0;
      rd_bank_reg  <= 1'b0;
      rd_addr_reg  <= '0;
      rd_group_reg <= '0;
      cnt_reg      <= '0;
      fin_bank_reg <= 1'b0;
    end else begin
      wr_bank_reg  <= wr_bank_next;
      wr_addr_reg  <= wr_addr_next;
      rd_bank_reg  <= rd_bank_next;
      rd_addr_reg  <= rd_addr_next;
      rd_group_reg <= rd_group_next;
      cnt_reg      <= cnt_next;
      fin_bank_reg <= fin_bank_next;
    end
  end

endmodule

// File: tb/tb_cbfp0_grp_sched.sv
`timescale 1ns/1ps
// Testbench for cbfp0_grp_sched. A queue-based reference model tracks
// completed groups (by the cycle their min becomes valid) and predicts every
// output each cycle; scenario tasks add targeted checks on top.
module tb_cbfp0_grp_sched;
  localparam int GL  = 16;
  localparam int NG  = 32;
  localparam int LAT = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       din_valid = 1'b0;
  logic       scale_ready = 1'b0;
  logic       din_ready, min_clr, min_acc_en, wr_en, wr_bank;
  logic [3:0] wr_addr, rd_addr;
  logic       min_fin_en, fin_bank, rd_en, rd_bank, frame_done;
  logic [4:0] rd_group;

  cbfp0_grp_sched #(.GROUP_LEN(GL), .NUM_GROUPS(NG), .LAT_MIN(LAT)) dut (
    .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_ready(din_ready),
    .scale_ready(scale_ready), .min_clr(min_clr), .min_acc_en(min_acc_en),
    .wr_en(wr_en), .wr_bank(wr_bank), .wr_addr(wr_addr),
    .min_fin_en(min_fin_en), .fin_bank(fin_bank), .rd_en(rd_en),
    .rd_bank(rd_bank), .rd_addr(rd_addr), .rd_group(rd_group),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model state
  int  m_wr_cnt, m_rd_cnt, m_rd_group, m_cycle, m_total;
  bit  m_wr_bank, m_rd_bank;
  int  q_fin[$];   // per buffered group: cycle at which its min is valid

  bit  e_ready, e_acc, e_clr, e_fin, e_fin_bank, e_rd, e_frame;
  logic [22:0] exp_vec;

  function automatic logic [22:0] obs_vec();
    return {din_ready, min_clr, min_acc_en, wr_en, wr_bank, wr_addr,
            min_fin_en, min_fin_en & fin_bank, rd_en, rd_bank, rd_addr,
            rd_group, frame_done};
  endfunction

  task automatic model_reset();
    m_wr_cnt = 0; m_rd_cnt = 0; m_rd_group = 0; m_cycle = 0; m_total = 0;
    m_wr_bank = 0; m_rd_bank = 0;
    q_fin.delete();
  endtask

  // Drive one cycle of inputs, then predict that cycle's outputs and advance
  // the model as if the next clock edge has taken them.
  task automatic cycle(input bit v, input bit s);
    @(posedge clk); #1;
    din_valid = v; scale_ready = s;
    @(negedge clk);
    e_ready = (m_wr_cnt > 0) || (q_fin.size() < 2);
    e_acc   = v && e_ready;
    e_clr   = e_acc && (m_wr_cnt == 0);
    e_fin = 0; e_fin_bank = 0;
    foreach (q_fin[i]) if (q_fin[i] == m_cycle) begin
      e_fin = 1; e_fin_bank = m_rd_bank ^ (i % 2 == 1);
    end
    e_rd    = (q_fin.size() > 0) && (m_cycle > q_fin[0]) && s;
    e_frame = e_rd && (m_rd_cnt == GL-1) && (m_rd_group == NG-1);
    exp_vec = {e_ready, e_clr, e_acc, e_acc, m_wr_bank, 4'(m_wr_cnt), e_fin,
               e_fin_bank, e_rd, m_rd_bank, 4'(m_rd_cnt), 5'(m_rd_group), e_frame};
    if (e_rd) begin
      m_rd_cnt++;
      if (m_rd_cnt == GL) begin
        void'(q_fin.pop_front());
        m_rd_cnt = 0; m_rd_bank = ~m_rd_bank; m_rd_group = (m_rd_group + 1) % NG;
      end
    end
    if (e_acc) begin
      m_wr_cnt++; m_total++;
      if (m_wr_cnt == GL) begin
        q_fin.push_back(m_cycle + LAT);
        m_wr_cnt = 0; m_wr_bank = ~m_wr_bank;
      end
    end
    m_cycle++;
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rstn = 0; din_valid = 0; scale_ready = 0;
    repeat (n) @(posedge clk);
    #1 rstn = 1;
    model_reset();
  endtask

  task automatic test_reset();
    rstn = 0; din_valid = 1; scale_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({din_ready, rd_en, min_fin_en, wr_en} !== 4'b0000)
      $display("FAIL reset_strobes got=%b exp=0000", {din_ready, rd_en, min_fin_en, wr_en});
    else n_pass++;
    @(posedge clk); #1;
    rstn = 1; din_valid = 0; scale_ready = 0;
    model_reset();
    @(negedge clk);
    n_checks++;
    if (obs_vec() !== {1'b1, 22'b0})
      $display("FAIL reset_state got=%h exp=%h", obs_vec(), {1'b1, 22'b0});
    else n_pass++;
  endtask

  task automatic test_single_group();
    int fin_at = -1, rd_first = -1, rd_cnt = 0;
    bit fin_b = 1, clr_ok = 0;
    do_reset(1);
    for (int k = 0; k < 45; k++) begin
      cycle(k < GL, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL single_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (k == 0) clr_ok = (min_clr === 1'b1) && (wr_addr === 4'd0) && (wr_bank === 1'b0);
      if (min_fin_en === 1'b1) begin fin_at = k; fin_b = fin_bank; end
      if (rd_en === 1'b1) begin
        if (rd_first < 0) rd_first = k;
        rd_cnt++;
      end
    end
    n_checks++;
    if (!clr_ok) $display("FAIL single_clr got=0 exp=1");
    else n_pass++;
    n_checks++;
    if (fin_at !== 19 || fin_b !== 1'b0)
      $display("FAIL single_fin got=cyc%0d/bank%0d exp=cyc19/bank0", fin_at, fin_b);
    else n_pass++;
    n_checks++;
    if (rd_first !== 20 || rd_cnt !== GL)
      $display("FAIL single_rd got=first%0d/n%0d exp=first20/n16", rd_first, rd_cnt);
    else n_pass++;
  endtask

  task automatic test_three_groups();
    int n_acc = 0, stall = 0;
    bit gap01 = 0, g2_seen = 0, g2_bank = 1;
    logic [3:0] g2_addr = 4'hf;
    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      cycle(1'b1, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL three_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (k < 2*GL && wr_en !== 1'b1) gap01 = 1;
      if (n_acc == 2*GL && din_ready !== 1'b1) stall++;
      if (wr_en === 1'b1) begin
        if (n_acc == 2*GL) begin g2_seen = 1; g2_bank = wr_bank; g2_addr = wr_addr; end
        n_acc++;
      end
    end
    n_checks++;
    if (gap01) $display("FAIL three_g01_gap got=stall exp=none");
    else n_pass++;
    n_checks++;
    if (stall !== LAT) $display("FAIL three_stall got=%0d exp=%0d", stall, LAT);
    else n_pass++;
    n_checks++;
    if (!g2_seen || g2_bank !== 1'b0 || g2_addr !== 4'd0)
      $display("FAIL three_g2 got=seen%0d/bank%0d/addr%0d exp=1/0/0", g2_seen, g2_bank, g2_addr);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    int n_acc = 0, n_fin = 0, n_rd = 0;
    bit [1:0] fin_b = 2'b11;
    do_reset(1);
    for (int k = 0; k < 60; k++) begin
      cycle(k < 48, 1'b0);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL bp_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (wr_en === 1'b1) n_acc++;
      if (rd_en === 1'b1) n_rd++;
      if (min_fin_en === 1'b1) begin
        if (n_fin < 2) fin_b[n_fin] = fin_bank;
        n_fin++;
      end
    end
    n_checks++;
    if (n_acc !== 2*GL || din_ready !== 1'b0)
      $display("FAIL bp_accept got=%0d/rdy%0d exp=32/rdy0", n_acc, din_ready);
    else n_pass++;
    n_checks++;
    if (n_fin !== 2 || fin_b !== 2'b10 || n_rd !== 0)
      $display("FAIL bp_fin got=n%0d/banks%b/rd%0d exp=n2/banks10/rd0", n_fin, fin_b, n_rd);
    else n_pass++;
    for (int k = 0; k < 40; k++) begin
      cycle(1'b0, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL bp_drain_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (rd_en === 1'b1) begin
        n_checks++;
        if (rd_bank !== 1'((n_rd / GL) % 2) || rd_addr !== 4'(n_rd % GL))
          $display("FAIL bp_order idx=%0d got=b%0d/a%0d exp=b%0d/a%0d",
                   n_rd, rd_bank, rd_addr, (n_rd / GL) % 2, n_rd % GL);
        else n_pass++;
        n_rd++;
      end
    end
    n_checks++;
    if (n_rd !== 2*GL) $display("FAIL bp_drain_cnt got=%0d exp=32", n_rd);
    else n_pass++;
  endtask

  task automatic test_toggle();
    int n_rd = 0;
    do_reset(1);
    for (int k = 0; k < 80; k++) begin
      cycle(k < GL, (k % 2) == 0);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL toggle_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (rd_en === 1'b1) begin
        n_checks++;
        if (rd_addr !== 4'(n_rd) || scale_ready !== 1'b1)
          $display("FAIL toggle_addr idx=%0d got=%0d exp=%0d", n_rd, rd_addr, n_rd);
        else n_pass++;
        n_rd++;
      end
    end
    n_checks++;
    if (n_rd !== GL) $display("FAIL toggle_cnt got=%0d exp=16", n_rd);
    else n_pass++;
  endtask

  task automatic test_frame();
    int n_frame = 0;
    do_reset(1);
    for (int k = 0; k < 900; k++) begin
      cycle(m_total < NG*GL, 1'b1);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL frame_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
      if (frame_done === 1'b1) begin
        n_frame++;
        n_checks++;
        if (rd_en !== 1'b1 || rd_group !== 5'(NG-1) || rd_addr !== 4'(GL-1))
          $display("FAIL frame_pos got=rd%0d/g%0d/a%0d exp=rd1/g31/a15", rd_en, rd_group, rd_addr);
        else n_pass++;
      end
    end
    n_checks++;
    if (n_frame !== 1 || rd_group !== 5'd0)
      $display("FAIL frame_once got=n%0d/g%0d exp=n1/g0", n_frame, rd_group);
    else n_pass++;
  endtask

  task automatic test_random();
    do_reset(1);
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
      n_checks++;
      if (obs_vec() !== exp_vec)
        $display("FAIL random_vec cyc=%0d got=%h exp=%h", k, obs_vec(), exp_vec);
      else n_pass++;
    end
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    do_reset(1);
    // One full group then two beats: countdown is still pending at reset.
    for (int k = 0; k < GL + 2; k++) cycle(1'b1, 1'b1);
    do_reset(1);
    for (int k = 0; k < 25; k++) begin
      cycle(1'b0, 1'b1);
      if (min_fin_en !== 1'b0 || rd_en !== 1'b0) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midrst_quiet got=%0d exp=0", bad);
    else n_pass++;
    for (int k = 0; k < 7; k++) cycle(1'b1, 1'b1);
    n_checks++;
    if (wr_addr !== 4'd6 || wr_en !== 1'b1)
      $display("FAIL midrst_pre got=a%0d/en%0d exp=a6/en1", wr_addr, wr_en);
    else n_pass++;
    do_reset(1);
    cycle(1'b1, 1'b1);
    n_checks++;
    if ({wr_en, min_clr, wr_bank, wr_addr} !== {1'b1, 1'b1, 1'b0, 4'd0})
      $display("FAIL midrst_restart got=%b exp=%b", {wr_en, min_clr, wr_bank, wr_addr},
               {1'b1, 1'b1, 1'b0, 4'd0});
    else n_pass++;
    n_checks++;
    if (obs_vec() !== exp_vec)
      $display("FAIL midrst_vec got=%h exp=%h", obs_vec(), exp_vec);
    else n_pass++;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_group();
    test_three_groups();
    test_backpressure();
    test_toggle();
    test_frame();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
